// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// RV32I general-purpose register file with an integrated write-back
// scoreboard. Decode reads rs1/rs2 combinationally; a same-cycle write-back is
// forwarded straight onto the read ports. Each architectural register carries
// one busy bit that is set when an instruction writing it issues and cleared
// when its result is written back. Decode is stalled while it needs a source
// whose result is still in flight.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   rs1_addr_i, rs2_addr_i   : source indices from decode
//   rs1_used_i, rs2_used_i   : decode instruction actually reads that source
//   rs1_data_o, rs2_data_o   : source values (combinational, with WB bypass)
//   issue_valid_i            : decode instruction leaves decode if not stalled
//   issue_rd_we_i            : issuing instruction writes a destination
//   issue_rd_i               : destination index of the issuing instruction
//   wb_en_i, wb_addr_i,
//   wb_data_i                : write-back port
//   stall_o                  : hold decode and upstream (combinational)
//   busy_o                   : scoreboard vector, bit 0 (x0) always 0
//
// Issue handshake: issue_valid_i is the "valid", ~stall_o is the "ready". An
// issue is accepted on a rising edge exactly when both are high in that cycle;
// otherwise decode must hold its instruction and issue_valid_i stays asserted.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int REG_NUM = 32,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         rs1_addr_i,
  input  logic [4:0]         rs2_addr_i,
  input  logic               rs1_used_i,
  input  logic               rs2_used_i,
  output logic [DW-1:0]      rs1_data_o,
  output logic [DW-1:0]      rs2_data_o,
  input  logic               issue_valid_i,
  input  logic               issue_rd_we_i,
  input  logic [4:0]         issue_rd_i,
  input  logic               wb_en_i,
  input  logic [4:0]         wb_addr_i,
  input  logic [DW-1:0]      wb_data_i,
  output logic               stall_o,
  output logic [REG_NUM-1:0] busy_o
);

  // x0 has no storage at all: it reads as zero and can never become busy.
  logic [DW-1:0]      r_regs [REG_NUM-1:1];
  logic [REG_NUM-1:1] r_busy;

  logic [DW-1:0]      w_rs1_reg;
  logic [DW-1:0]      w_rs2_reg;
  logic               w_rs1_busy_bit;
  logic               w_rs2_busy_bit;
  logic               w_rs1_wb_hit;
  logic               w_rs2_wb_hit;
  logic               w_rs1_busy_eff;
  logic               w_rs2_busy_eff;
  logic               w_stall;
  logic               w_issue_accept;
  logic [REG_NUM-1:1] w_busy_next;

  // ---------------------------------------------------------------------------
  // Read path: register lookup. Address 0 (and any index beyond REG_NUM-1)
  // falls through to the zero default.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rs1_reg      = '0;
    w_rs2_reg      = '0;
    w_rs1_busy_bit = 1'b0;
    w_rs2_busy_bit = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (rs1_addr_i == 5'(i)) begin
        w_rs1_reg      = r_regs[i];
        w_rs1_busy_bit = r_busy[i];
      end
      if (rs2_addr_i == 5'(i)) begin
        w_rs2_reg      = r_regs[i];
        w_rs2_busy_bit = r_busy[i];
      end
    end
  end

  // A write-back to x0 is discarded, so it must not be bypassed either.
  assign w_rs1_wb_hit = wb_en_i && (wb_addr_i == rs1_addr_i) && (rs1_addr_i != 5'd0);
  assign w_rs2_wb_hit = wb_en_i && (wb_addr_i == rs2_addr_i) && (rs2_addr_i != 5'd0);

  assign rs1_data_o = w_rs1_wb_hit ? wb_data_i : w_rs1_reg;
  assign rs2_data_o = w_rs2_wb_hit ? wb_data_i : w_rs2_reg;

  // ---------------------------------------------------------------------------
  // Hazard detection. A source whose result arrives this very cycle is not a
  // hazard: the bypass above already delivers the value.
  // ---------------------------------------------------------------------------
  assign w_rs1_busy_eff = w_rs1_busy_bit && !w_rs1_wb_hit;
  assign w_rs2_busy_eff = w_rs2_busy_bit && !w_rs2_wb_hit;

  assign w_stall        = (rs1_used_i && w_rs1_busy_eff) ||
                          (rs2_used_i && w_rs2_busy_eff);
  assign w_issue_accept = issue_valid_i && !w_stall;

  assign stall_o = w_stall;

  // ---------------------------------------------------------------------------
  // Scoreboard next state. Clear on write-back first, then set on issue, so a
  // same-register collision leaves the bit set: the newly issued instruction is
  // the current owner of that register.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 1; i < REG_NUM; i++) begin
      if (wb_en_i && (wb_addr_i == 5'(i))) begin
        w_busy_next[i] = 1'b0;
      end
      if (w_issue_accept && issue_rd_we_i && (issue_rd_i == 5'(i))) begin
        w_busy_next[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset discards every in-flight producer along with data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 1; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_busy <= w_busy_next;
      for (int i = 1; i < REG_NUM; i++) begin
        if (wb_en_i && (wb_addr_i == 5'(i))) begin
          r_regs[i] <= wb_data_i;
        end
      end
    end
  end

  assign busy_o = {r_busy, 1'b0};

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Directed scenarios for the register file / scoreboard plus a short random
// write/read sweep. Expected values are pushed to exp_q as stimulus is driven
// and popped when the DUT outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int REG_NUM = 32;
  localparam int DW      = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [4:0]         rs1_addr_i;
  logic [4:0]         rs2_addr_i;
  logic               rs1_used_i;
  logic               rs2_used_i;
  logic [DW-1:0]      rs1_data_o;
  logic [DW-1:0]      rs2_data_o;
  logic               issue_valid_i;
  logic               issue_rd_we_i;
  logic [4:0]         issue_rd_i;
  logic               wb_en_i;
  logic [4:0]         wb_addr_i;
  logic [DW-1:0]      wb_data_i;
  logic               stall_o;
  logic [REG_NUM-1:0] busy_o;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] mdl [REG_NUM];
  int            vectors = 0;
  int            errors  = 0;

  regfile_sb #(.REG_NUM(REG_NUM), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_used_i    (rs1_used_i),
    .rs2_used_i    (rs2_used_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_we_i (issue_rd_we_i),
    .issue_rd_i    (issue_rd_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .stall_o       (stall_o),
    .busy_o        (busy_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst           = 1'b0;
    rs1_addr_i    = 5'd0;
    rs2_addr_i    = 5'd0;
    rs1_used_i    = 1'b0;
    rs2_used_i    = 1'b0;
    issue_valid_i = 1'b0;
    issue_rd_we_i = 1'b0;
    issue_rd_i    = 5'd0;
    wb_en_i       = 1'b0;
    wb_addr_i     = 5'd0;
    wb_data_i     = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_wb(input logic [4:0] a, input logic [DW-1:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    issue_valid_i = 1'b1;
    issue_rd_we_i = 1'b1;
    issue_rd_i    = rd;
  endtask

  task automatic clear_controls();
    issue_valid_i = 1'b0;
    issue_rd_we_i = 1'b0;
    wb_en_i       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst        = 1'b0;
    rs1_used_i = 1'b1;
    rs2_used_i = 1'b1;
    for (int a = 0; a < REG_NUM; a++) begin
      rs1_addr_i = 5'(a);
      rs2_addr_i = 5'(REG_NUM - 1 - a);
      exp_q.push_back('0);
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs1_data_o !== exp_v) begin
        $display("FAIL reset_rs1 addr=%0d got=%h exp=%h", a, rs1_data_o, exp_v);
        errors++;
      end
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs2_data_o !== exp_v) begin
        $display("FAIL reset_rs2 addr=%0d got=%h exp=%h", REG_NUM - 1 - a, rs2_data_o, exp_v);
        errors++;
      end
      vectors++;
      if (stall_o !== 1'b0) begin
        $display("FAIL reset_stall addr=%0d got=%b exp=0", a, stall_o);
        errors++;
      end
      next_cycle();
    end
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (busy_o !== exp_v) begin
      $display("FAIL reset_busy got=%h exp=%h", busy_o, exp_v);
      errors++;
    end
    next_cycle();
    // x0 ignores writes and is never bypassed.
    rs1_used_i = 1'b0;
    rs2_used_i = 1'b0;
    rs1_addr_i = 5'd0;
    drive_wb(5'd0, 32'hDEADBEEF);
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs1_data_o !== exp_v) begin
      $display("FAIL x0_bypass got=%h exp=%h", rs1_data_o, exp_v);
      errors++;
    end
    next_cycle();
    clear_controls();
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs1_data_o !== exp_v) begin
      $display("FAIL x0_read got=%h exp=%h", rs1_data_o, exp_v);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_bypass();
    drive_idle();
    drive_wb(5'd5, 32'h12345678);
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd5;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(32'h12345678);
      exp_q.push_back(32'h12345678);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs1_data_o !== exp_v) begin
        $display("FAIL bypass_rs1 cycle=%0d got=%h exp=%h", c, rs1_data_o, exp_v);
        errors++;
      end
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs2_data_o !== exp_v) begin
        $display("FAIL bypass_rs2 cycle=%0d got=%h exp=%h", c, rs2_data_o, exp_v);
        errors++;
      end
      next_cycle();
      clear_controls();
    end
  endtask

  task automatic test_raw_stall();
    drive_idle();
    drive_issue(5'd7);
    next_cycle();
    clear_controls();
    rs2_used_i = 1'b1;
    rs2_addr_i = 5'd7;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vectors++;
      if (32'(stall_o) !== exp_v) begin
        $display("FAIL raw_stall cycle=%0d got=%b exp=%0d", c, stall_o, exp_v);
        errors++;
      end
      exp_v = exp_q.pop_front();
      vectors++;
      if (32'(busy_o[7]) !== exp_v) begin
        $display("FAIL raw_busy7 cycle=%0d got=%b exp=%0d", c, busy_o[7], exp_v);
        errors++;
      end
      next_cycle();
    end
    drive_wb(5'd7, 32'hA5A5A5A5);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hA5A5A5A5);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(stall_o) !== exp_v) begin
      $display("FAIL raw_wb_stall got=%b exp=%0d", stall_o, exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs2_data_o !== exp_v) begin
      $display("FAIL raw_wb_data got=%h exp=%h", rs2_data_o, exp_v);
      errors++;
    end
    next_cycle();
    clear_controls();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hA5A5A5A5);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(busy_o[7]) !== exp_v) begin
      $display("FAIL raw_after_busy7 got=%b exp=%0d", busy_o[7], exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(stall_o) !== exp_v) begin
      $display("FAIL raw_after_stall got=%b exp=%0d", stall_o, exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs2_data_o !== exp_v) begin
      $display("FAIL raw_after_data got=%h exp=%h", rs2_data_o, exp_v);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    drive_idle();
    drive_issue(5'd9);
    drive_wb(5'd9, 32'h00000001);
    next_cycle();
    clear_controls();
    rs1_addr_i = 5'd9;
    rs1_used_i = 1'b1;
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs1_data_o !== exp_v) begin
      $display("FAIL same_data9 got=%h exp=%h", rs1_data_o, exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(busy_o[9]) !== exp_v) begin
      $display("FAIL same_busy9 got=%b exp=%0d", busy_o[9], exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(stall_o) !== exp_v) begin
      $display("FAIL same_stall got=%b exp=%0d", stall_o, exp_v);
      errors++;
    end
    // Retire the second producer so later scenarios start clean.
    drive_wb(5'd9, 32'h00000002);
    next_cycle();
    clear_controls();
    rs1_used_i = 1'b0;
  endtask

  task automatic test_issue_blocked();
    drive_idle();
    drive_issue(5'd2);
    next_cycle();
    clear_controls();
    rs1_used_i = 1'b1;
    rs1_addr_i = 5'd2;
    drive_issue(5'd3);
    exp_q.push_back(32'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(stall_o) !== exp_v) begin
      $display("FAIL blocked_stall got=%b exp=%0d", stall_o, exp_v);
      errors++;
    end
    next_cycle();
    clear_controls();
    rs1_used_i = 1'b0;
    exp_q.push_back(32'h00000004);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (busy_o !== exp_v) begin
      $display("FAIL blocked_busy got=%h exp=%h", busy_o, exp_v);
      errors++;
    end
    drive_issue(5'd0);
    next_cycle();
    clear_controls();
    exp_q.push_back(32'h00000004);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (busy_o !== exp_v) begin
      $display("FAIL issue_x0_busy got=%h exp=%h", busy_o, exp_v);
      errors++;
    end
    drive_wb(5'd2, 32'h0000CAFE);
    next_cycle();
    clear_controls();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    drive_wb(5'd4, 32'h44444444);
    next_cycle();
    clear_controls();
    drive_issue(5'd4);
    next_cycle();
    drive_issue(5'd6);
    next_cycle();
    clear_controls();
    exp_q.push_back(32'h00000050);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (busy_o !== exp_v) begin
      $display("FAIL mid_busy_pre got=%h exp=%h", busy_o, exp_v);
      errors++;
    end
    rst = 1'b1;
    next_cycle();
    rst        = 1'b0;
    rs1_addr_i = 5'd4;
    rs1_used_i = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    vectors++;
    if (busy_o !== exp_v) begin
      $display("FAIL mid_busy_post got=%h exp=%h", busy_o, exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (rs1_data_o !== exp_v) begin
      $display("FAIL mid_x4 got=%h exp=%h", rs1_data_o, exp_v);
      errors++;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (32'(stall_o) !== exp_v) begin
      $display("FAIL mid_stall got=%b exp=%0d", stall_o, exp_v);
      errors++;
    end
    rs1_used_i = 1'b0;
    for (int a = 1; a < REG_NUM; a++) begin
      rs1_addr_i = 5'(a);
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs1_data_o !== exp_v) begin
        $display("FAIL mid_clear addr=%0d got=%h exp=%h", a, rs1_data_o, exp_v);
        errors++;
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [4:0]    a;
    logic [DW-1:0] d;
    drive_idle();
    for (int i = 0; i < REG_NUM; i++) mdl[i] = '0;
    for (int n = 0; n < 24; n++) begin
      a = 5'($urandom_range(1, REG_NUM - 1));
      d = $urandom;
      drive_wb(a, d);
      mdl[a] = d;
      next_cycle();
      clear_controls();
      rs1_addr_i = 5'($urandom_range(0, REG_NUM - 1));
      rs2_addr_i = (n % 2 == 0) ? a : 5'($urandom_range(0, REG_NUM - 1));
      exp_q.push_back(mdl[rs1_addr_i]);
      exp_q.push_back(mdl[rs2_addr_i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs1_data_o !== exp_v) begin
        $display("FAIL rand_rs1 addr=%0d got=%h exp=%h", rs1_addr_i, rs1_data_o, exp_v);
        errors++;
      end
      exp_v = exp_q.pop_front();
      vectors++;
      if (rs2_data_o !== exp_v) begin
        $display("FAIL rand_rs2 addr=%0d got=%h exp=%h", rs2_addr_i, rs2_data_o, exp_v);
        errors++;
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    drive_idle();
    rst = 1'b1;
    next_cycle();
    test_reset();
    test_bypass();
    test_raw_stall();
    test_same_cycle();
    test_issue_blocked();
    test_reset_mid();
    test_random();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      errors++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
